mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//  Initiator-side controller for the single-port synchronous `memory` block: drives addr/data/we, captures q.
//  Accepts one command (read or write, base address, burst length) via valid/ready handshake.
//  Sequences up to 16 words at consecutive addresses, streams read data out, and takes write data in.
//  Sits between the accumulator datapath/control FSM and the memory instance.
// PARAMETERS
//  DATA_WIDTH   16  word width; must match the memory's DATA_WIDTH
//  ADDR_WIDTH   10  address width; must match the memory's ADDR_WIDTH
//  LEN_WIDTH    4   burst length field width; burst = cmd_len+1 words (1..16)
//  MEM_LATENCY  1   cycles from the clock edge that samples mem_addr to mem_q valid (>=1)
// PORTS
//  clk         in   1           rising-edge clock
//  reset_n     in   1           synchronous reset, active low
//  cmd_valid   in   1           command present
//  cmd_ready   out  1           controller can accept a command (high only in IDLE)
//  cmd_write   in   1           1 = write burst, 0 = read burst
//  cmd_addr    in   ADDR_WIDTH  burst base address
//  cmd_len     in   LEN_WIDTH   words minus one
//  wr_valid    in   1           write word present on wr_data
//  wr_ready    out  1           write word accepted this cycle when wr_valid is also high
//  wr_data     in   DATA_WIDTH  write word
//  rd_valid    out  1           read word valid (one-cycle pulse per word; no backpressure)
//  rd_data     out  DATA_WIDTH  read word
//  busy        out  1           command in progress
//  done        out  1           one-cycle pulse when the burst completes
//  verify_err  out  1           sticky write-verify mismatch (see CONFIGURATION)
//  mem_addr    out  ADDR_WIDTH  to memory addr (registered)
//  mem_data    out  DATA_WIDTH  to memory data (registered)
//  mem_we      out  1           to memory we (registered)
//  mem_q       in   DATA_WIDTH  from memory q
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE.
//    Reset values: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, verify_err=0,
//    mem_addr=0, mem_data=0, mem_we=0.
//  - Reset mid-burst: in-flight reads are discarded; no rd_valid or done follows; mem_we=0 from the next cycle.
//  - Command accept: cmd_valid & cmd_ready at an edge. Latch addr/len/write; busy=1 from the next cycle.
//    Clear verify_err. Next state is WRITE or READ.
//  - WRITE: wr_ready=1.
//    * On wr_valid & wr_ready: register mem_addr=cur_addr, mem_data=wr_data, mem_we=1 for exactly one cycle.
//    * Advance cur_addr and decrement the remaining-word count.
//    * No wr_valid: mem_we=0, nothing advances.
//    * After the last word: wr_ready=0, then done=1 in the cycle the last mem_we=1 is visible. Return to IDLE.
//  - READ: issue one address per cycle, mem_we=0, until all words are issued.
//    * Then wait in DRAIN for outstanding reads.
//    * A tag shift register of depth MEM_LATENCY marks issued slots.
//    * mem_q is captured into rd_data with rd_valid=1 in cycle t+MEM_LATENCY+1, where t = cycle mem_addr shows the word.
//    * Words are returned in address order.
//    * done=1 in the same cycle as the last rd_valid. Return to IDLE.
//  - Address arithmetic: cur_addr increments modulo 2^ADDR_WIDTH, so 0x3FF wraps to 0x000. No error is raised.
//  - busy=1 from the cycle after accept through the done cycle inclusive. cmd_ready = ~busy.
//  - cmd_valid while busy is ignored; the command is held by the requester until cmd_ready.
//  - wr_valid outside WRITE is ignored; wr_ready=0 there.
//  - mem_we is never 1 in READ or DRAIN. A read burst never modifies memory.
// CONFIGURATION
//  MEM_BURST_CTRL_VERIFY_EN
//  - Defined: after each written word the FSM enters VERIFY.
//    * It drives the same mem_addr with mem_we=0 and waits MEM_LATENCY+1 cycles.
//    * It compares mem_q to the written word; a mismatch sets verify_err (sticky until the next accept).
//    * wr_ready=0 during VERIFY. Write throughput is 1 word per MEM_LATENCY+2 cycles.
//  - Undefined: no VERIFY state, verify_err tied 0, write throughput is 1 word per cycle.
// TESTING
//  - Memory preloaded 0x000..0x003 = 1234,1337,DEAD,BEEF (hex).
//  - T1 reset: hold reset_n=0 2 cycles with cmd_valid=1 -> all outputs at reset values, cmd_ready=1, mem_we never 1.
//  - T2 read burst: addr=0x000, len=3 -> rd_data 1234,1337,DEAD,BEEF on 4 consecutive rd_valid cycles.
//    First rd_valid 2 cycles after the first mem_addr; done with the 4th word.
//  - T3 write then read: write addr=0x003, len=0, data=1111.
//    * mem_we=1 for exactly 1 cycle with mem_addr=0x003.
//    * A following read of 0x003 returns 1111.
//  - T4 wrap: write addr=0x3FF, len=1, data AAAA,5555 -> writes hit 0x3FF then 0x000.
//    A read addr=0x3FF, len=1 returns AAAA,5555.
//  - T5 stalls/overlap: write len=2 with wr_valid gaps of 2 cycles -> exactly 3 mem_we pulses.
//    A cmd_valid pulse mid-burst is not accepted (cmd_ready=0); done arrives once.
//  - T6 reset mid-read: assert reset_n=0 one cycle after accepting a read of len=3 -> no rd_valid, no done.
//    A next read of 0x001 returns 1337. With VERIFY_EN, a forced mem_q mismatch sets verify_err=1.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst sequencer between a command requester and a single-port synchronous memory
// Defining MEM_BURST_CTRL_VERIFY_EN adds a read-back verify pass after every written word.
module mem_burst_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH   = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

`ifdef MEM_BURST_CTRL_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, VERIFY} state_t;
  localparam int VW = $clog2(MEM_LATENCY + 2);
  localparam logic [VW-1:0] V_OPEN = VW'(MEM_LATENCY);
  localparam logic [VW-1:0] V_CMP  = VW'(MEM_LATENCY + 1);
  logic [VW-1:0] vcnt;
  logic          last_word;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  // tag[0] marks a read address on mem_addr; tag[MEM_LATENCY] means mem_q holds that word now
  logic [MEM_LATENCY:0]  tag;
  logic                  word_take;

  assign word_take = wr_valid && wr_ready;

`ifndef MEM_BURST_CTRL_VERIFY_EN
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      tag       <= '0;
`ifdef MEM_BURST_CTRL_VERIFY_EN
      verify_err <= 1'b0;
      vcnt       <= '0;
      last_word  <= 1'b0;
`endif
    end else begin
      mem_we   <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      tag      <= {tag[MEM_LATENCY-1:0], 1'b0};

      if (tag[MEM_LATENCY]) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_q;
      end

      if (word_take) begin
        mem_addr  <= cur_addr;
        mem_data  <= wr_data;
        mem_we    <= 1'b1;
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      case (state)
        IDLE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            wr_ready  <= cmd_write;
            state     <= cmd_write ? WRITE : READ;
`ifdef MEM_BURST_CTRL_VERIFY_EN
            verify_err <= 1'b0;
`endif
          end
        end

        WRITE: begin
          if (word_take) begin
`ifdef MEM_BURST_CTRL_VERIFY_EN
            wr_ready  <= 1'b0;
            vcnt      <= '0;
            last_word <= (remaining == '0);
            state     <= VERIFY;
`else
            if (remaining == '0) begin
              wr_ready <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
`endif
          end
        end

`ifdef MEM_BURST_CTRL_VERIFY_EN
        // mem_addr/mem_data still hold the written word; mem_we has dropped so it is re-read
        VERIFY: begin
          vcnt <= vcnt + 1'b1;
          if (vcnt == V_OPEN && !last_word) wr_ready <= 1'b1;
          if (vcnt == V_CMP) begin
            if (mem_q != mem_data) verify_err <= 1'b1;
            if (last_word) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (word_take) begin
              wr_ready  <= 1'b0;
              vcnt      <= '0;
              last_word <= (remaining == '0);
            end else begin
              state <= WRITE;
            end
          end
        end
`endif

        READ: begin
          mem_addr <= cur_addr;
          cur_addr <= cur_addr + 1'b1;
          tag[0]   <= 1'b1;
          if (remaining == '0) state <= DRAIN;
          else remaining <= remaining - 1'b1;
        end

        DRAIN: begin
          if (tag[MEM_LATENCY] && tag[MEM_LATENCY-1:0] == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - self-checking bench for mem_burst_ctrl against a behavioural memory and array model
// Optional MEM_BURST_CTRL_VERIFY_EN section exercises the verify mismatch flag.
module tb_mem_burst_ctrl;
  localparam int DW = 16, AW = 10, LW = 4, LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready;
  logic [AW-1:0] cmd_addr, mem_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data, mem_data, mem_q;
  logic          rd_valid, busy, done, verify_err, mem_we;

  mem_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .verify_err(verify_err), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  // single-port synchronous memory, read latency 1; force_bad corrupts the read path only
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] mem_q_raw;
  logic          force_bad = 1'b0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q_raw <= mem[mem_addr];
  end
  assign mem_q = mem_q_raw ^ (force_bad ? 16'h0001 : 16'h0000);

  logic [DW-1:0] ref_mem [0:1023];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, we_cnt = 0, done_cnt = 0, we_in_read = 0;
  int first_rd_cyc = -1, last_rd_cyc = -1, done_cyc = -1, last_we_cyc = -1;
  bit in_read = 1'b0;
  logic [DW-1:0] rd_q[$];
  logic [AW-1:0] we_addr_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      we_cnt++;
      we_addr_q.push_back(mem_addr);
      last_we_cyc = cyc;
      if (in_read) we_in_read++;
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) first_rd_cyc = cyc;
      rd_q.push_back(rd_data);
      last_rd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    we_cnt = 0; done_cnt = 0; we_in_read = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; done_cyc = -1; last_we_cyc = -1;
    rd_q.delete();
    we_addr_q.delete();
  endtask

  task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l, output int acc_cyc);
    bit acc = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    check("cmd_accept", acc, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) tick();
    check(name, busy, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] d [16], input int gap, input bit poke);
    int  acc_cyc, k;
    bit  poked = 1'b0;
    logic [AW-1:0] ai;
    clear_mon();
    in_read = 1'b0;
    send_cmd(1'b1, a, l, acc_cyc);
    k = 0;
    for (int c = 0; c < 400 && k <= int'(l); c++) begin
      wr_valid = 1'b1;
      wr_data  = d[k];
      if (poke && !poked && k == 1) begin
        poked = 1'b1;
        cmd_valid = 1'b1;
        check("cmd_ready_while_busy", cmd_ready, 0);
      end
      if (wr_ready) begin
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        k++;
        repeat (gap) tick();
      end else begin
        tick();
        cmd_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    check("wr_all_words_taken", k, int'(l) + 1);
    wait_idle("wr_idle");
    check("wr_we_pulses", we_cnt, int'(l) + 1);
    check("wr_done_once", done_cnt, 1);
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + AW'(i);
      if (i < we_addr_q.size()) check("wr_addr", we_addr_q[i], ai);
      ref_mem[ai] = d[i];
    end
`ifndef MEM_BURST_CTRL_VERIFY_EN
    check("wr_done_with_last_we", done_cyc, last_we_cyc);
    if (gap == 0) check("wr_throughput", done_cyc, acc_cyc + int'(l) + 1);
`endif
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int acc_cyc;
    logic [AW-1:0] ai;
    clear_mon();
    in_read = 1'b1;
    send_cmd(1'b0, a, l, acc_cyc);
    wait_idle("rd_idle");
    in_read = 1'b0;
    check("rd_count", rd_q.size(), int'(l) + 1);
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + AW'(i);
      if (i < rd_q.size()) check("rd_word_vs_model", rd_q[i], ref_mem[ai]);
    end
    check("rd_first_latency", first_rd_cyc, acc_cyc + LAT + 2);
    check("rd_done_with_last", done_cyc, last_rd_cyc);
    check("rd_done_once", done_cnt, 1);
    check("rd_no_we", we_in_read, 0);
  endtask

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [3:0][DW-1:0] w;
  } vec_t;

  function automatic vec_t mkv(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [DW-1:0] w0, w1, w2, w3);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  vec_t          vecs [6];
  logic [DW-1:0] dbuf [16];
  int            dummy;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[0] = 16'h1234; mem[1] = 16'h1337; mem[2] = 16'hDEAD; mem[3] = 16'hBEEF;
    ref_mem[0] = 16'h1234; ref_mem[1] = 16'h1337; ref_mem[2] = 16'hDEAD; ref_mem[3] = 16'hBEEF;

    vecs[0] = mkv(1'b0, 10'h000, 4'd3, 16'h1234, 16'h1337, 16'hDEAD, 16'hBEEF);
    vecs[1] = mkv(1'b1, 10'h003, 4'd0, 16'h1111, 16'h0000, 16'h0000, 16'h0000);
    vecs[2] = mkv(1'b0, 10'h003, 4'd0, 16'h1111, 16'h0000, 16'h0000, 16'h0000);
    vecs[3] = mkv(1'b1, 10'h3FF, 4'd1, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    vecs[4] = mkv(1'b0, 10'h3FF, 4'd1, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
    vecs[5] = mkv(1'b0, 10'h000, 4'd1, 16'h5555, 16'h1337, 16'h0000, 16'h0000);

    // reset held two cycles with a pending command
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    tick(); tick();
    clear_mon();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_verify_err", verify_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_no_we", we_cnt, 0);
    cmd_valid = 1'b0; wr_valid = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_ready", cmd_ready, 1);

    // directed table: read preload, write/readback, wrap-around
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) dbuf[i] = (i < 4) ? vecs[t].w[i] : 16'h0000;
      if (vecs[t].wr) begin
        do_write(vecs[t].addr, vecs[t].len, dbuf, 0, 1'b0);
      end else begin
        do_read(vecs[t].addr, vecs[t].len);
        for (int i = 0; i <= int'(vecs[t].len); i++)
          if (i < rd_q.size()) check($sformatf("vec%0d_word%0d", t, i), rd_q[i], vecs[t].w[i]);
      end
    end
    check("wrap_mem_3ff", mem[10'h3FF], 16'hAAAA);
    check("wrap_mem_000", mem[10'h000], 16'h5555);

    // stalled write with an ignored mid-burst command pulse
    for (int i = 0; i < 16; i++) dbuf[i] = 16'h7000 + DW'(i);
    do_write(10'h020, 4'd2, dbuf, 2, 1'b1);
    repeat (3) tick();
    check("stall_no_extra_cmd", busy, 0);
    do_read(10'h020, 4'd2);

    // reset one cycle after a read is accepted
    clear_mon();
    send_cmd(1'b0, 10'h000, 4'd3, dummy);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("midrst_no_rd_valid", rd_q.size(), 0);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_we", we_cnt, 0);
    check("midrst_ready", cmd_ready, 1);
    do_read(10'h001, 4'd0);
    if (rd_q.size() > 0) check("midrst_read_001", rd_q[0], 16'h1337);

`ifdef MEM_BURST_CTRL_VERIFY_EN
    force_bad = 1'b1;
    for (int i = 0; i < 16; i++) dbuf[i] = 16'h4242;
    do_write(10'h030, 4'd0, dbuf, 0, 1'b0);
    force_bad = 1'b0;
    check("verify_err_set", verify_err, 1);
    do_write(10'h031, 4'd1, dbuf, 0, 1'b0);
    check("verify_err_cleared", verify_err, 0);
`endif

    // randomized commands around the wrap boundary against the array model
    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;
      ra = AW'($urandom_range(0, 31) + 1008);
      rl = LW'($urandom_range(0, 15));
      if (r == 0 || $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) dbuf[i] = DW'($urandom);
        do_write(ra, rl, dbuf, $urandom_range(0, 2), 1'b0);
      end else begin
        do_read(ra, rl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
